ifetch_line_buffer: RTL and testbench
=====================================

IFETCH_LINE_BUFFER -- requirements
Module: ifetch_line_buffer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, with all state updated on posedge clk.
REQ-002 SHALL provide these ports, clock and reset first:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- core_req  in  1  fetch request valid
- core_addr  in  32  fetch byte address; bits [1:0] ignored
- invalidate  in  1  fence.i line invalidate
- core_inst  out  32  instruction word
- core_wait  out  1  fetch stall, drives I_core_wait of the PC generator
- mem_arvalid  out  1  line read request
- mem_arready  in  1  request accepted
- mem_araddr  out  32  line address, bits [3:0]=0
- mem_rvalid  in  1  read beat valid; always accepted, no ready
- mem_rdata  in  32  beat data
- mem_rlast  in  1  last beat; informational only

Function
REQ-003 SHALL hold one 4-word line: data[0:3], tag[31:4], valid bit.
REQ-004 SHALL define hit = valid & (tag == core_addr[31:4]), combinational.
REQ-005 SHALL drive core_inst = data[core_addr[3:2]] every cycle, regardless of hit.
REQ-006 SHALL drive core_wait = core_req & ~(hit & state==IDLE), combinational.
REQ-007 SHALL implement FSM states IDLE, AR, RD.
- IDLE -> AR when core_req & ~hit; latch fill_tag = core_addr[31:4].
- AR: mem_arvalid=1, mem_araddr={fill_tag,4'b0}; -> RD on mem_arvalid & mem_arready.
- RD: on each mem_rvalid, write data[beat_cnt] and increment 2-bit beat_cnt.
- RD -> IDLE on the beat with beat_cnt==3.
REQ-008 SHALL keep mem_arvalid and mem_araddr stable in AR until arready is sampled high.
REQ-009 SHALL clear valid on entry to AR and reset beat_cnt to 0 there.
REQ-010 SHALL, on the 4th beat, set tag=fill_tag and valid=1, unless inval_pend is set.
REQ-011 SHALL end the burst by beat count; mem_rlast SHALL NOT affect the FSM.
REQ-012 SHALL give a cold-miss latency of 6 cycles when arready and rvalid are immediate:
- cycle 0: miss in IDLE, wait=1
- cycle 1: AR accepted
- cycles 2-5: beats 0-3
- cycle 6: hit, wait=0
REQ-013 SHALL always complete an in-flight fill, with no abort, when core_addr changes mid-fill.
- Line is stored under fill_tag.
- New address is evaluated in IDLE the cycle after the fill completes.
REQ-014 SHALL, on invalidate in IDLE, clear valid the next cycle.
REQ-015 SHALL, on invalidate in AR or RD, set inval_pend.
- Fill completes with valid left 0.
- inval_pend clears on return to IDLE.
REQ-016 SHALL ignore mem_rvalid in IDLE and AR.
REQ-017 SHALL give invalidate priority over setting valid when both occur in the same cycle.

Reset
REQ-018 SHALL, on rst, set:
- state=IDLE, valid=0, inval_pend=0, beat_cnt=0
- tag=0, fill_tag=0, data[0:3]=0
REQ-019 SHALL yield these outputs during and after reset:
- mem_arvalid=0, mem_araddr=0, core_inst=0
- core_wait=core_req
REQ-020 SHALL have rst take effect mid-fill; any later beats are ignored in IDLE and the line is not marked valid.

Verification
REQ-021 Cold miss: reset, core_req=1, addr=0x100, arready=1, beats 0xA0..0xA3 back-to-back.
- mem_araddr=0x100 in cycle 1.
- core_wait=0 with core_inst=0xA0 in cycle 6.
- addr=0x10C then gives 0xA3 with no wait.
REQ-022 Backpressure: arready held 0 for 3 cycles, rvalid gapped 1-on/1-off.
- arvalid and araddr stable throughout AR.
- Exactly 4 beats captured; wait held until the cycle after the 4th beat.
REQ-023 Redirect mid-fill: addr 0x200 miss, switch to 0x300 during beat 1.
- Fill completes under tag 0x20.
- IDLE then issues a new AR at 0x300.
- A later 0x204 request hits only if no refill occurred.
REQ-024 Invalidate mid-fill: pulse invalidate during beat 2 of a 0x400 fill.
- After beat 3, valid=0.
- Request 0x400 misses again and issues AR at 0x400.
REQ-025 Reset mid-fill: assert rst during beat 1.
- Next cycle: state IDLE, arvalid=0, valid=0.
- Stray rvalid beats cause no write; core_inst=0.
REQ-026 Same-cycle invalidate and final beat: invalidate coincides with the 4th beat.
- valid stays 0.
- Next request to the same line misses.

Source files
------------

// File: rtl/ifetch_line_buffer.sv
// Single-line instruction fetch buffer: holds one 4-word line and refills it
// from memory with a 4-beat burst on a miss.
module ifetch_line_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic [31:0] core_addr,
  input  logic        invalidate,
  output logic [31:0] core_inst,
  output logic        core_wait,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  output logic [31:0] mem_araddr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rlast
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OFF_W  = 4;
  localparam int unsigned TAG_W  = ADDR_W - OFF_W;
  localparam int unsigned WORDS  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    RD   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [TAG_W-1:0]    tag_q;
  logic [TAG_W-1:0]    fill_tag_q;
  logic [ADDR_W-1:0]   data_q [WORDS];
  logic                valid_q;
  logic                inval_pend_q;
  logic [1:0]          beat_cnt_q;
  logic                hit_c;
  logic                unused_inputs;

  // The burst length is fixed, so rlast and the byte offset carry no information here.
  assign unused_inputs = &{1'b0, mem_rlast, core_addr[1:0]};

  assign hit_c     = valid_q && (tag_q == core_addr[ADDR_W-1:OFF_W]);
  assign core_inst = data_q[core_addr[3:2]];
  assign core_wait = core_req && !(hit_c && (state_q == IDLE));

  // Next-state and memory request outputs
  always_comb begin
    state_d     = state_q;
    mem_arvalid = 1'b0;
    mem_araddr  = '0;
    case (state_q)
      IDLE: begin
        if (core_req && !hit_c) begin
          state_d = AR;
        end
      end
      AR: begin
        mem_arvalid = 1'b1;
        mem_araddr  = {fill_tag_q, OFF_W'(0)};
        if (mem_arready) begin
          state_d = RD;
        end
      end
      RD: begin
        if (mem_rvalid && (beat_cnt_q == 2'd3)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and line storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      inval_pend_q <= 1'b0;
      beat_cnt_q   <= 2'd0;
      tag_q        <= '0;
      fill_tag_q   <= '0;
      for (int i = 0; i < int'(WORDS); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          inval_pend_q <= 1'b0;
          if (invalidate) begin
            valid_q <= 1'b0;
          end
          if (state_d == AR) begin
            fill_tag_q <= core_addr[ADDR_W-1:OFF_W];
            valid_q    <= 1'b0;
            beat_cnt_q <= 2'd0;
          end
        end
        AR: begin
          if (invalidate) begin
            inval_pend_q <= 1'b1;
          end
        end
        RD: begin
          if (invalidate) begin
            inval_pend_q <= 1'b1;
          end
          if (mem_rvalid) begin
            data_q[beat_cnt_q] <= mem_rdata;
            beat_cnt_q         <= beat_cnt_q + 2'd1;
            // Final beat: publish the line unless an invalidate arrived during the fill.
            if (beat_cnt_q == 2'd3) begin
              inval_pend_q <= 1'b0;
              if (!inval_pend_q && !invalidate) begin
                valid_q <= 1'b1;
                tag_q   <= fill_tag_q;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_line_buffer.sv
// Testbench for ifetch_line_buffer: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model of the line buffer.
`timescale 1ns/1ps
module tb_ifetch_line_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req;
  logic [31:0] core_addr;
  logic        invalidate;
  logic [31:0] core_inst;
  logic        core_wait;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [31:0] mem_araddr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rlast;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the stored line plus the progress of any fill in flight
  logic [31:0] m_data [4];
  bit          m_valid;
  logic [27:0] m_tag;
  bit          m_busy;      // a fill is in flight
  bit          m_ar;        // fill still waiting for its address handshake
  int          m_got;       // beats received so far
  bit          m_inval;     // invalidate seen while busy
  logic [27:0] m_fill_tag;

  always #5 clk = ~clk;

  ifetch_line_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .core_req    (core_req),
    .core_addr   (core_addr),
    .invalidate  (invalidate),
    .core_inst   (core_inst),
    .core_wait   (core_wait),
    .mem_arvalid (mem_arvalid),
    .mem_arready (mem_arready),
    .mem_araddr  (mem_araddr),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .mem_rlast   (mem_rlast)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_data[i] = 32'h0;
    m_valid    = 1'b0;
    m_tag      = 28'h0;
    m_busy     = 1'b0;
    m_ar       = 1'b0;
    m_got      = 0;
    m_inval    = 1'b0;
    m_fill_tag = 28'h0;
  endtask

  // Compare outputs against the model, then advance both one clock.
  task automatic tick();
    bit hit;
    #1;
    hit = m_valid && (m_tag == core_addr[31:4]);
    check("core_inst",   core_inst,   m_data[core_addr[3:2]]);
    check("core_wait",   {31'h0, core_wait}, {31'h0, core_req && !(hit && !m_busy)});
    check("mem_arvalid", {31'h0, mem_arvalid}, {31'h0, m_ar});
    check("mem_araddr",  mem_araddr,  m_ar ? {m_fill_tag, 4'h0} : 32'h0);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (invalidate) m_valid = 1'b0;
      if (core_req && !hit) begin
        m_busy     = 1'b1;
        m_ar       = 1'b1;
        m_fill_tag = core_addr[31:4];
        m_valid    = 1'b0;
        m_got      = 0;
        m_inval    = 1'b0;
      end
    end else if (m_ar) begin
      if (invalidate) m_inval = 1'b1;
      if (mem_arready) m_ar = 1'b0;
    end else begin
      if (invalidate) m_inval = 1'b1;
      if (mem_rvalid) begin
        m_data[m_got] = mem_rdata;
        m_got++;
        if (m_got == 4) begin
          m_busy = 1'b0;
          if (!m_inval) begin
            m_valid = 1'b1;
            m_tag   = m_fill_tag;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    rst = 1'b1; core_req = 1'b1; core_addr = 32'h0; invalidate = 1'b0;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_rlast = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_wait_eq_req", {31'h0, core_wait}, 32'h1);
    check("reset_arvalid", {31'h0, mem_arvalid}, 32'h0);
    tick();

    // Cold miss at 0x100 with immediate handshakes
    rst = 1'b0; core_addr = 32'h100; mem_arready = 1'b1;
    #1 check("cold_c0_wait", {31'h0, core_wait}, 32'h1);
    tick();
    #1 check("cold_c1_araddr", mem_araddr, 32'h100);
    check("cold_c1_arvalid", {31'h0, mem_arvalid}, 32'h1);
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hA0 + 32'(i); mem_rlast = (i == 3);
      #1 check("cold_beat_wait", {31'h0, core_wait}, 32'h1);
      tick();
    end
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    #1 check("cold_c6_wait", {31'h0, core_wait}, 32'h0);
    check("cold_c6_inst", core_inst, 32'hA0);
    tick();
    core_addr = 32'h10C;
    #1 check("cold_hit_10c", core_inst, 32'hA3);
    check("cold_hit_10c_wait", {31'h0, core_wait}, 32'h0);
    tick();

    // Invalidate coinciding with the final beat leaves the line invalid
    core_addr = 32'h500;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'h50 + 32'(i); invalidate = (i == 3);
      tick();
    end
    mem_rvalid = 1'b0; invalidate = 1'b0;
    #1 check("inval_last_wait", {31'h0, core_wait}, 32'h1);
    tick();
    #1 check("inval_last_rearm", mem_araddr, 32'h500);
    tick();

    // Randomized traffic over a small set of lines so hits and refills both occur
    for (int c = 0; c < 4000; c++) begin
      rst         = ($urandom_range(0, 149) == 0);
      core_req    = ($urandom_range(0, 3) != 0);
      core_addr   = 32'h1000 + (32'($urandom_range(0, 5)) << 4) + 32'($urandom_range(0, 15));
      invalidate  = ($urandom_range(0, 24) == 0);
      mem_arready = ($urandom_range(0, 2) != 0);
      mem_rvalid  = ($urandom_range(0, 1) != 0);
      mem_rdata   = $urandom;
      mem_rlast   = ($urandom_range(0, 1) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
